pkt_task_sequencer: RTL and testbench
=====================================

Name: pkt_task_sequencer

Overview:
Control stage directly upstream of the packet builder and packet parser register ports. Accepts one packet task at a time and drives the builder port: program, start, wait for irq. It then drives the parser port with the builder's output address, collects the parser status and checks it against the expected result. One result record is returned per task, and running packet and error counters are kept.

Parameters:
TIMEOUT_CYCLES, 1024, max cycles waiting for pb_irq or pp_irq per stage (>=2)
CNT_W, 16, width of pkt_cnt/err_cnt

Ports:
clk  in  1  single clock
rst_n  in  1  synchronous active-low reset
task_valid  in  1  task offered
task_ready  out  1  task accepted when valid&ready
task_cfg  in  97  {ignore_ecc_err, addr_out[31:0], data_sel[3:0], sop_val[2:0], crc_val[7:0], ecc_val[3:0], ins_crc_err, ins_ecc_err[1:0], crc_en, ecc_en, pkt_type[3:0], byte_cnt[3:0], addr_in[31:0]}, MSB first
pb_start  out  1  one-cycle start pulse to builder
pb_addr_in..pb_addr_out  out  per pb port widths  builder config (addr_in 32, byte_cnt 4, pkt_type 4, ecc_en 1, crc_en 1, ins_ecc_err 2, ins_crc_err 1, ecc_val 4, crc_val 8, sop_val 3, data_sel 4, addr_out 32)
pb_busy  in  1  builder busy
pb_irq  in  1  builder done
pp_start  out  1  one-cycle start pulse to parser
pp_addr_hdr  out  32  = latched addr_out
pp_ignore_ecc_err  out  1  = latched ignore_ecc_err
pp_busy, pp_irq  in  1 each  parser busy / done
pp_pkt_ecc_corr, pp_pkt_ecc_uncorr, pp_pkt_crc_err  in  1 each  parser status
pp_pkt_byte_cnt, pp_pkt_type  in  4 each  parser decoded fields
res_valid  out  1  result record valid
res_ready  in  1  result consumed when valid&ready
res_status  out  9  {timeout, timeout_stage(0=pb,1=pp), mismatch, ecc_corr, ecc_uncorr, crc_err, match_cnt, match_type, match_err}
pkt_cnt  out  CNT_W  completed tasks (saturating)
err_cnt  out  CNT_W  tasks with timeout or mismatch (saturating)

Behaviour:
- Reset (rst_n=0 at clk edge): state IDLE; every output 0 except task_ready=1; counters 0; latched config 0. Mid-task reset aborts with no result record.
- States: IDLE -> PB_ARM -> PB_WAIT -> PP_ARM -> PP_WAIT -> RESULT -> IDLE.
- IDLE: task_ready=1. On valid&ready, latch task_cfg, drive pb config outputs from the latch (held stable until the next accept), go to PB_ARM. task_ready=0 in every other state.
- PB_ARM: wait while pb_busy=1. First cycle with pb_busy=0: pb_start=1 for exactly that cycle, clear the timer, go to PB_WAIT.
- PB_WAIT: timer increments each cycle. pb_irq=1 -> PP_ARM. Otherwise, timer==TIMEOUT_CYCLES-1 -> RESULT with timeout=1, stage=0. irq and timeout in the same cycle: irq wins.
- PP_ARM / PP_WAIT: same rules using pp_busy, pp_start, pp_irq; timeout stage=1. pp_addr_hdr and pp_ignore_ecc_err are valid from PP_ARM entry onward.
- On pp_irq: capture parser status and compare fields into the res registers.
- Expected errors:
  - exp_crc = crc_en & ins_crc_err.
  - If ecc_en=0, or ins_ecc_err=00: expect corr=0, uncorr=0.
  - ins_ecc_err=01: expect corr=1, uncorr=0.
  - ins_ecc_err=1x: expect corr=0, uncorr=1.
- match_cnt = (pp_pkt_byte_cnt==byte_cnt); match_type = (pp_pkt_type==pkt_type); match_err = all three error flags equal their expected values; mismatch = ~(match_cnt&match_type&match_err).
- On a timeout, the captured status and match fields are 0 and mismatch=0.
- RESULT: res_valid=1, res_status held stable until res_ready=1. On handshake: pkt_cnt+1, err_cnt+1 if timeout|mismatch (both saturate at all-ones), then go to IDLE.
- No pipelining: exactly one task in flight, and the next task_ready follows the cycle after the result handshake.

Test Plan:
- Clean task (byte_cnt=5, type=3, no error insertion); pb_irq 10 cycles after start, pp returns cnt=5, type=3, no errors -> one pb_start and one pp_start pulse, pp_addr_hdr=addr_out, res_status mismatch=0, pkt_cnt=1, err_cnt=0.
- pb_busy=1 for 4 cycles after accept -> pb_start asserts in the first cycle busy=0, never earlier.
- ecc_en=1, ins_ecc_err=01; parser reports ecc_corr=1 -> match_err=1. Same task with parser reporting uncorr=1 -> mismatch=1, err_cnt=1.
- TIMEOUT_CYCLES=8, pp_irq never asserted -> RESULT entered 8 cycles after pp_start, timeout=1, stage=1, err_cnt incremented.
- res_ready held 0 for 5 cycles -> res_status stable, task_ready=0 throughout; accept of the next task possible only after the handshake.
- rst_n=0 during PB_WAIT -> all outputs at reset values next cycle, no res_valid, counters 0.

Source files
------------

// File: rtl/pkt_task_sequencer.sv
// Packet task sequencer: runs one builder -> parser task at a time,
// checks the parser status against the expected result, keeps counters.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   task_valid/ready    task handshake, task_cfg is the 97-bit task word:
//                       {ignore_ecc_err, addr_out, data_sel, sop_val,
//                        crc_val, ecc_val, ins_crc_err, ins_ecc_err,
//                        crc_en, ecc_en, pkt_type, byte_cnt, addr_in}
//   pb_*                builder config, start pulse, busy/irq
//   pp_*                parser header addr, start pulse, busy/irq, status
//   res_valid/ready     result handshake, res_status is
//                       {timeout, timeout_stage, mismatch, ecc_corr,
//                        ecc_uncorr, crc_err, match_cnt, match_type,
//                        match_err}
//   pkt_cnt, err_cnt    saturating completed / failed task counters
module pkt_task_sequencer #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             task_valid,
    output logic             task_ready,
    input  logic [96:0]      task_cfg,

    output logic             pb_start,
    output logic [31:0]      pb_addr_in,
    output logic [3:0]       pb_byte_cnt,
    output logic [3:0]       pb_pkt_type,
    output logic             pb_ecc_en,
    output logic             pb_crc_en,
    output logic [1:0]       pb_ins_ecc_err,
    output logic             pb_ins_crc_err,
    output logic [3:0]       pb_ecc_val,
    output logic [7:0]       pb_crc_val,
    output logic [2:0]       pb_sop_val,
    output logic [3:0]       pb_data_sel,
    output logic [31:0]      pb_addr_out,
    input  logic             pb_busy,
    input  logic             pb_irq,

    output logic             pp_start,
    output logic [31:0]      pp_addr_hdr,
    output logic             pp_ignore_ecc_err,
    input  logic             pp_busy,
    input  logic             pp_irq,
    input  logic             pp_pkt_ecc_corr,
    input  logic             pp_pkt_ecc_uncorr,
    input  logic             pp_pkt_crc_err,
    input  logic [3:0]       pp_pkt_byte_cnt,
    input  logic [3:0]       pp_pkt_type,

    output logic             res_valid,
    input  logic             res_ready,
    output logic [8:0]       res_status,

    output logic [CNT_W-1:0] pkt_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        PB_ARM,
        PB_WAIT,
        PP_ARM,
        PP_WAIT,
        RESULT
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [96:0]   cfg_q;
    logic [TW-1:0] timer_q;
    logic [8:0]    res_q;
    logic [CNT_W-1:0] pkt_q;
    logic [CNT_W-1:0] err_q;

    logic accept;
    logic cap_pp;
    logic to_pb;
    logic to_pp;
    logic res_done;
    logic timer_end;

    logic exp_corr;
    logic exp_uncorr;
    logic exp_crc;
    logic match_cnt;
    logic match_type;
    logic match_err;
    logic [8:0] cap_status;

    // Latched task word feeds the port configuration directly.
    assign pp_ignore_ecc_err = cfg_q[96];
    assign pb_addr_out       = cfg_q[95:64];
    assign pb_data_sel       = cfg_q[63:60];
    assign pb_sop_val        = cfg_q[59:57];
    assign pb_crc_val        = cfg_q[56:49];
    assign pb_ecc_val        = cfg_q[48:45];
    assign pb_ins_crc_err    = cfg_q[44];
    assign pb_ins_ecc_err    = cfg_q[43:42];
    assign pb_crc_en         = cfg_q[41];
    assign pb_ecc_en         = cfg_q[40];
    assign pb_pkt_type       = cfg_q[39:36];
    assign pb_byte_cnt       = cfg_q[35:32];
    assign pb_addr_in        = cfg_q[31:0];
    assign pp_addr_hdr       = cfg_q[95:64];

    assign res_status = res_q;
    assign pkt_cnt    = pkt_q;
    assign err_cnt    = err_q;

    assign timer_end = (timer_q == TIMER_LAST);

    // Error insertion on the builder side predicts the parser flags.
    // Any ins_ecc_err with the MSB set is a double-bit (uncorrectable) error.
    assign exp_crc    = pb_crc_en & pb_ins_crc_err;
    assign exp_corr   = pb_ecc_en & (pb_ins_ecc_err == 2'b01);
    assign exp_uncorr = pb_ecc_en & pb_ins_ecc_err[1];

    assign match_cnt  = (pp_pkt_byte_cnt == pb_byte_cnt);
    assign match_type = (pp_pkt_type == pb_pkt_type);
    assign match_err  = (pp_pkt_ecc_corr == exp_corr)
                      & (pp_pkt_ecc_uncorr == exp_uncorr)
                      & (pp_pkt_crc_err == exp_crc);

    assign cap_status = {
        2'b00,
        ~(match_cnt & match_type & match_err),
        pp_pkt_ecc_corr,
        pp_pkt_ecc_uncorr,
        pp_pkt_crc_err,
        match_cnt,
        match_type,
        match_err
    };

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        task_ready = 1'b0;
        pb_start   = 1'b0;
        pp_start   = 1'b0;
        res_valid  = 1'b0;
        accept     = 1'b0;
        cap_pp     = 1'b0;
        to_pb      = 1'b0;
        to_pp      = 1'b0;
        res_done   = 1'b0;
        unique case (state_q)
            IDLE: begin
                task_ready = 1'b1;
                if (task_valid) begin
                    accept  = 1'b1;
                    state_d = PB_ARM;
                end
            end
            PB_ARM: begin
                if (!pb_busy) begin
                    pb_start = 1'b1;
                    state_d  = PB_WAIT;
                end
            end
            PB_WAIT: begin
                // irq has priority over a timeout in the same cycle
                if (pb_irq) begin
                    state_d = PP_ARM;
                end else if (timer_end) begin
                    to_pb   = 1'b1;
                    state_d = RESULT;
                end
            end
            PP_ARM: begin
                if (!pp_busy) begin
                    pp_start = 1'b1;
                    state_d  = PP_WAIT;
                end
            end
            PP_WAIT: begin
                if (pp_irq) begin
                    cap_pp  = 1'b1;
                    state_d = RESULT;
                end else if (timer_end) begin
                    to_pp   = 1'b1;
                    state_d = RESULT;
                end
            end
            RESULT: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    res_done = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cfg_q   <= '0;
            timer_q <= '0;
            res_q   <= '0;
            pkt_q   <= '0;
            err_q   <= '0;
        end else begin
            if (accept) begin
                cfg_q <= task_cfg;
            end

            // Timer restarts with each start pulse and only runs while
            // waiting for an irq; the FSM leaves before it can wrap.
            if (pb_start || pp_start) begin
                timer_q <= '0;
            end else if (state_q == PB_WAIT || state_q == PP_WAIT) begin
                timer_q <= timer_q + 1'b1;
            end

            if (cap_pp) begin
                res_q <= cap_status;
            end else if (to_pb) begin
                res_q <= 9'b10_0000000;
            end else if (to_pp) begin
                res_q <= 9'b11_0000000;
            end

            if (res_done) begin
                if (pkt_q != '1) begin
                    pkt_q <= pkt_q + 1'b1;
                end
                if ((res_q[8] || res_q[6]) && err_q != '1) begin
                    err_q <= err_q + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pkt_task_sequencer.sv
// Testbench for pkt_task_sequencer: builder/parser responders driven
// cycle by cycle, expected result records kept in a scoreboard queue.
module tb_pkt_task_sequencer;

    localparam int TO = 12;
    localparam int CW = 3;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          task_valid;
    logic          task_ready;
    logic [96:0]   task_cfg;
    logic          pb_start;
    logic [31:0]   pb_addr_in;
    logic [3:0]    pb_byte_cnt;
    logic [3:0]    pb_pkt_type;
    logic          pb_ecc_en;
    logic          pb_crc_en;
    logic [1:0]    pb_ins_ecc_err;
    logic          pb_ins_crc_err;
    logic [3:0]    pb_ecc_val;
    logic [7:0]    pb_crc_val;
    logic [2:0]    pb_sop_val;
    logic [3:0]    pb_data_sel;
    logic [31:0]   pb_addr_out;
    logic          pb_busy;
    logic          pb_irq;
    logic          pp_start;
    logic [31:0]   pp_addr_hdr;
    logic          pp_ignore_ecc_err;
    logic          pp_busy;
    logic          pp_irq;
    logic          pp_pkt_ecc_corr;
    logic          pp_pkt_ecc_uncorr;
    logic          pp_pkt_crc_err;
    logic [3:0]    pp_pkt_byte_cnt;
    logic [3:0]    pp_pkt_type;
    logic          res_valid;
    logic          res_ready;
    logic [8:0]    res_status;
    logic [CW-1:0] pkt_cnt;
    logic [CW-1:0] err_cnt;

    logic [95:0]   pb_all;
    logic [3:0]    ctl;

    assign pb_all = {pb_addr_out, pb_data_sel, pb_sop_val, pb_crc_val,
                     pb_ecc_val, pb_ins_crc_err, pb_ins_ecc_err,
                     pb_crc_en, pb_ecc_en, pb_pkt_type, pb_byte_cnt,
                     pb_addr_in};
    assign ctl = {task_ready, pb_start, pp_start, res_valid};

    always #5 clk = ~clk;

    pkt_task_sequencer #(
        .TIMEOUT_CYCLES(TO),
        .CNT_W(CW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .task_valid(task_valid),
        .task_ready(task_ready),
        .task_cfg(task_cfg),
        .pb_start(pb_start),
        .pb_addr_in(pb_addr_in),
        .pb_byte_cnt(pb_byte_cnt),
        .pb_pkt_type(pb_pkt_type),
        .pb_ecc_en(pb_ecc_en),
        .pb_crc_en(pb_crc_en),
        .pb_ins_ecc_err(pb_ins_ecc_err),
        .pb_ins_crc_err(pb_ins_crc_err),
        .pb_ecc_val(pb_ecc_val),
        .pb_crc_val(pb_crc_val),
        .pb_sop_val(pb_sop_val),
        .pb_data_sel(pb_data_sel),
        .pb_addr_out(pb_addr_out),
        .pb_busy(pb_busy),
        .pb_irq(pb_irq),
        .pp_start(pp_start),
        .pp_addr_hdr(pp_addr_hdr),
        .pp_ignore_ecc_err(pp_ignore_ecc_err),
        .pp_busy(pp_busy),
        .pp_irq(pp_irq),
        .pp_pkt_ecc_corr(pp_pkt_ecc_corr),
        .pp_pkt_ecc_uncorr(pp_pkt_ecc_uncorr),
        .pp_pkt_crc_err(pp_pkt_crc_err),
        .pp_pkt_byte_cnt(pp_pkt_byte_cnt),
        .pp_pkt_type(pp_pkt_type),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .res_status(res_status),
        .pkt_cnt(pkt_cnt),
        .err_cnt(err_cnt)
    );

    typedef struct {
        logic [8:0]    st;
        logic [CW-1:0] pkt;
        logic [CW-1:0] err;
    } exp_t;

    exp_t sb_q[$];
    int n_chk = 0;
    int n_err = 0;
    int m_pkt = 0;
    int m_err = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_idle();
        task_valid = 1'b0;
        task_cfg   = '0;
        pb_busy    = 1'b0;
        pb_irq     = 1'b0;
        pp_busy    = 1'b0;
        pp_irq     = 1'b0;
        res_ready  = 1'b0;
        {pp_pkt_ecc_corr, pp_pkt_ecc_uncorr, pp_pkt_crc_err,
         pp_pkt_byte_cnt, pp_pkt_type} = 11'($urandom);
    endtask

    task automatic chk_rst_outs();
        chk("rst_ctl", ctl, 4'b1000);
        chk("rst_pb", pb_all, 96'd0);
        chk("rst_pp", {pp_ignore_ecc_err, pp_addr_hdr}, 33'd0);
        chk("rst_res", res_status, 9'd0);
        chk("rst_pkt", pkt_cnt, 0);
        chk("rst_err", err_cnt, 0);
    endtask

    function automatic logic [96:0] mk_cfg(
        input logic ign, input logic ecc_en, input logic [1:0] ins_ecc,
        input logic crc_en, input logic ins_crc,
        input logic [3:0] typ, input logic [3:0] cnt);
        logic [31:0] ai;
        logic [31:0] ao;
        ai = $urandom;
        ao = $urandom;
        return {ign, ao, 4'($urandom), 3'($urandom), 8'($urandom),
                4'($urandom), ins_crc, ins_ecc, crc_en, ecc_en,
                typ, cnt, ai};
    endfunction

    // pst = {corr, uncorr, crc, byte_cnt[3:0], pkt_type[3:0]}
    // irq delay d: irq d cycles after start, 0 = never.
    function automatic logic [8:0] model(input logic [96:0] cfg,
                                         input logic [10:0] pst,
                                         input int pb_d, input int pp_d);
        logic e_crc, e_corr, e_unc, mc, mt, me;
        if (pb_d < 1 || pb_d > TO) return 9'b10_0000000;
        if (pp_d < 1 || pp_d > TO) return 9'b11_0000000;
        e_crc  = cfg[41] & cfg[44];
        e_corr = cfg[40] & (cfg[43:42] == 2'b01);
        e_unc  = cfg[40] & cfg[43];
        mc = (pst[7:4] == cfg[35:32]);
        mt = (pst[3:0] == cfg[39:36]);
        me = (pst[10] == e_corr) && (pst[9] == e_unc) && (pst[8] == e_crc);
        return {2'b00, ~(mc & mt & me), pst[10:8], mc, mt, me};
    endfunction

    task automatic run_task(input logic [96:0] cfg,
                            input int pb_bn, input int pb_d,
                            input int pp_bn, input int pp_d,
                            input logic [10:0] pst,
                            input int rdy_d, input int rst_at);
        exp_t e;
        exp_t got;
        logic [8:0] st_exp;
        logic [3:0] ctl_exp;
        int ph, bcnt, wcnt, rcnt, lim, t_pp, t_res;
        bit busy, irq;
        ph = 0; bcnt = 0; wcnt = 0; rcnt = 0; lim = 0;
        t_pp = -1000; t_res = -1;
        got.st = '0; got.pkt = '0; got.err = '0;
        st_exp = model(cfg, pst, pb_d, pp_d);
        if (rst_at < 0) begin
            if (m_pkt < CMAX) m_pkt++;
            if ((st_exp[8] || st_exp[6]) && m_err < CMAX) m_err++;
            e.st = st_exp;
            e.pkt = CW'(m_pkt);
            e.err = CW'(m_err);
            sb_q.push_back(e);
        end
        while (ph < 6 && lim < 300) begin
            @(negedge clk);
            lim++;
            drive_idle();
            task_valid = (ph == 0);
            task_cfg = cfg;
            busy = 1'b0;
            irq = 1'b0;
            case (ph)
                1: begin busy = (bcnt < pb_bn); pb_busy = busy; end
                2: begin
                    irq = (wcnt + 1 == pb_d);
                    pb_irq = irq;
                    if (rst_at == wcnt) rst_n = 1'b0;
                end
                3: begin busy = (bcnt < pp_bn); pp_busy = busy; end
                4: begin
                    irq = (wcnt + 1 == pp_d);
                    pp_irq = irq;
                    if (irq) begin
                        {pp_pkt_ecc_corr, pp_pkt_ecc_uncorr, pp_pkt_crc_err,
                         pp_pkt_byte_cnt, pp_pkt_type} = pst;
                    end
                end
                5: res_ready = (rcnt >= rdy_d);
                default: ;
            endcase
            #1;
            case (ph)
                0: ctl_exp = 4'b1000;
                1: ctl_exp = {1'b0, ~busy, 2'b00};
                3: ctl_exp = {2'b00, ~busy, 1'b0};
                5: ctl_exp = 4'b0001;
                default: ctl_exp = 4'b0000;
            endcase
            chk("ctl", ctl, ctl_exp);
            if (pp_start) t_pp = cyc;
            if (res_valid && t_res < 0) t_res = cyc;
            case (ph)
                0: begin ph = 1; bcnt = 0; end
                1: begin
                    if (busy) bcnt++;
                    else begin
                        chk("pb_cfg", pb_all, cfg[95:0]);
                        ph = 2;
                        wcnt = 0;
                    end
                end
                2: begin
                    if (rst_at == wcnt) ph = 7;
                    else if (irq) begin ph = 3; bcnt = 0; end
                    else if (wcnt + 1 == TO) ph = 5;
                    else wcnt++;
                end
                3: begin
                    if (busy) bcnt++;
                    else begin
                        chk("pp_cfg", {pp_ignore_ecc_err, pp_addr_hdr},
                            cfg[96:64]);
                        ph = 4;
                        wcnt = 0;
                    end
                end
                4: begin
                    if (irq || wcnt + 1 == TO) ph = 5;
                    else wcnt++;
                end
                5: begin
                    if (rcnt == 0) begin
                        chk("sb_size", sb_q.size(), 1);
                        if (sb_q.size() > 0) got = sb_q.pop_front();
                    end
                    chk("status", res_status, got.st);
                    if (res_ready) ph = 6;
                    else rcnt++;
                end
                default: ;
            endcase
        end
        if (rst_at < 0) begin
            chk("done", ph, 6);
            @(negedge clk);
            drive_idle();
            #1;
            chk("ctl_idle", ctl, 4'b1000);
            chk("pkt_cnt", pkt_cnt, got.pkt);
            chk("err_cnt", err_cnt, got.err);
            if (st_exp[8:7] == 2'b11) chk("to_lat", t_res - t_pp, TO + 1);
        end else begin
            chk("rst_hit", ph, 7);
            @(negedge clk);
            rst_n = 1'b1;
            drive_idle();
            #1;
            m_pkt = 0;
            m_err = 0;
            chk_rst_outs();
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                #1;
                chk("no_res", ctl, 4'b1000);
            end
        end
    endtask

    initial begin
        logic [96:0] c;
        drive_idle();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk_rst_outs();
        rst_n = 1'b1;

        c = mk_cfg(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 4'd3, 4'd5);
        run_task(c, 0, 10, 0, 3, {3'b000, 4'd5, 4'd3}, 0, -1);

        c = mk_cfg(1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 4'd7, 4'd2);
        run_task(c, 4, 2, 2, 2, {3'b000, 4'd2, 4'd7}, 1, -1);

        c = mk_cfg(1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 4'd1, 4'd9);
        run_task(c, 0, 4, 0, 5, {3'b100, 4'd9, 4'd1}, 0, -1);
        run_task(c, 0, 4, 0, 5, {3'b010, 4'd9, 4'd1}, 0, -1);

        c = mk_cfg(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 4'd2, 4'd2);
        run_task(c, 0, 3, 0, 0, {3'b000, 4'd2, 4'd2}, 0, -1);

        c = mk_cfg(1'b1, 1'b1, 2'b10, 1'b1, 1'b1, 4'd5, 4'd4);
        run_task(c, 1, 5, 1, 6, {3'b011, 4'd4, 4'd5}, 5, -1);

        c = mk_cfg(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 4'd8, 4'd15);
        run_task(c, 0, TO, 0, TO, {3'b000, 4'd15, 4'd8}, 0, -1);

        c = mk_cfg(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 4'd4, 4'd4);
        run_task(c, 0, 0, 0, 3, {3'b000, 4'd4, 4'd4}, 2, -1);

        c = mk_cfg(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 4'd6, 4'd6);
        run_task(c, 0, 2, 0, 2, {3'b000, 4'd7, 4'd6}, 0, -1);

        c = mk_cfg(1'b0, 1'b0, 2'b11, 1'b0, 1'b1, 4'd0, 4'd1);
        run_task(c, 0, 1, 0, 1, {3'b000, 4'd1, 4'd0}, 0, -1);

        c = mk_cfg(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 4'd3, 4'd5);
        run_task(c, 0, 10, 0, 3, {3'b000, 4'd5, 4'd3}, 0, 2);

        c = mk_cfg(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 4'd3, 4'd5);
        run_task(c, 0, 10, 0, 3, {3'b000, 4'd5, 4'd3}, 0, -1);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end

endmodule
